// File: rtl/sensor_frame_reader.sv
// sensor_frame_reader: readout sequencer for a linear optical sensor and its NUM_CH serial ADCs.
// Ports: fpga_clk/reset (async, active-low); start pulse and continuous mode in; serial_data ADC lines in;
// SI, sensor_clk, adc_sclk, chip_select drive the sensor and ADCs; data_out/pixel_idx qualified by
// the data_valid strobe; frame_done strobes at frame end; busy is high outside IDLE.
// Optional: define FRAME_SUM_EN to add frame_sum, the per-channel sum of every word in the frame.
module sensor_frame_reader #(
  parameter int NUM_CH     = 2,
  parameter int ADC_BITS   = 12,
  parameter int CONV_CYC   = 16,
  parameter int SCLK_HALF  = 2,
  parameter int QUIET_CYC  = 8,
  parameter int NUM_PIXELS = 128
) (
  input  logic                            fpga_clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            continuous,
  input  logic [NUM_CH-1:0]               serial_data,
  output logic                            SI,
  output logic                            sensor_clk,
  output logic                            adc_sclk,
  output logic                            chip_select,
  output logic [NUM_CH*ADC_BITS-1:0]      data_out,
  output logic                            data_valid,
  output logic [$clog2(NUM_PIXELS)-1:0]   pixel_idx,
  output logic                            frame_done,
  output logic                            busy
`ifdef FRAME_SUM_EN
  ,
  output logic [NUM_CH*(ADC_BITS+$clog2(NUM_PIXELS))-1:0] frame_sum
`endif
);
  localparam int PW = $clog2(NUM_PIXELS);
  localparam int CONV_LEN = CONV_CYC * 2 * SCLK_HALF;
  localparam int CW = $clog2(CONV_LEN > QUIET_CYC ? CONV_LEN : QUIET_CYC);
  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam int DW = NUM_CH * ADC_BITS;
  typedef enum logic [2:0] {IDLE, SI_PULSE, CONVERT, QUIET, FRAME_END} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [PW-1:0] pix_q, pix_d, pidx_q, pidx_d;
  logic [DW-1:0] sr_q, sr_d, data_q, data_d;
  logic si_q, si_d, sensor_clk_q, sensor_clk_d, sclk_q, sclk_d, cs_q, cs_d;
  logic valid_q, valid_d, done_q, done_d, busy_q, busy_d;
  logic conv_exit, rise, si_entry, half_end;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = start ? SI_PULSE : IDLE;
      SI_PULSE:  state_d = (cyc_q == CW'(QUIET_CYC - 1)) ? CONVERT : SI_PULSE;
      CONVERT:   state_d = (cyc_q == CW'(CONV_LEN - 1)) ? QUIET : CONVERT;
      QUIET:     state_d = (cyc_q != CW'(QUIET_CYC - 1)) ? QUIET :
                           (pix_q < PW'(NUM_PIXELS - 1)) ? CONVERT : FRAME_END;
      FRAME_END: state_d = continuous ? SI_PULSE : IDLE;
      default:   state_d = IDLE;
    endcase
    half_end = hcnt_q == HW'(SCLK_HALF - 1);
    conv_exit = state_q == CONVERT && state_d == QUIET;
    si_entry = state_d == SI_PULSE && state_q != SI_PULSE;
    // serial data is captured on the edge that raises adc_sclk
    rise = state_q == CONVERT && state_d == CONVERT && !sclk_q && half_end;
    cyc_d = (state_d != state_q || state_q == IDLE) ? '0 : cyc_q + 1'b1;
    hcnt_d = (state_d != CONVERT || state_q != CONVERT || half_end) ? '0 : hcnt_q + 1'b1;
    sclk_d = state_d != CONVERT ? 1'b1 : state_q != CONVERT ? 1'b0 : half_end ? ~sclk_q : sclk_q;
    sr_d = sr_q;
    for (int k = 0; k < NUM_CH; k++)
      sr_d[k*ADC_BITS +: ADC_BITS] = rise ? {sr_q[k*ADC_BITS +: ADC_BITS-1], serial_data[k]}
                                          : sr_q[k*ADC_BITS +: ADC_BITS];
    pix_d = si_entry ? '0 : (state_q == QUIET && state_d == CONVERT) ? pix_q + 1'b1 : pix_q;
    data_d = conv_exit ? sr_q : data_q;
    pidx_d = conv_exit ? pix_q : pidx_q;
    valid_d = conv_exit;
    si_d = state_d == SI_PULSE;
    sensor_clk_d = state_d == SI_PULSE || state_d == QUIET;
    cs_d = state_d != CONVERT;
    done_d = state_d == FRAME_END;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge fpga_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cyc_q <= '0;
      hcnt_q <= '0;
      pix_q <= '0;
      pidx_q <= '0;
      sr_q <= '0;
      data_q <= '0;
      si_q <= 1'b0;
      sensor_clk_q <= 1'b0;
      sclk_q <= 1'b1;
      cs_q <= 1'b1;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      hcnt_q <= hcnt_d;
      pix_q <= pix_d;
      pidx_q <= pidx_d;
      sr_q <= sr_d;
      data_q <= data_d;
      si_q <= si_d;
      sensor_clk_q <= sensor_clk_d;
      sclk_q <= sclk_d;
      cs_q <= cs_d;
      valid_q <= valid_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign SI = si_q;
  assign sensor_clk = sensor_clk_q;
  assign adc_sclk = sclk_q;
  assign chip_select = cs_q;
  assign data_out = data_q;
  assign data_valid = valid_q;
  assign pixel_idx = pidx_q;
  assign frame_done = done_q;
  assign busy = busy_q;
`ifdef FRAME_SUM_EN
  localparam int SW = ADC_BITS + PW;
  logic [NUM_CH*SW-1:0] acc_q, acc_d, fsum_q, fsum_d;
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < NUM_CH; k++)
      acc_d[k*SW +: SW] = si_entry ? '0 :
                          valid_q ? acc_q[k*SW +: SW] + SW'(data_q[k*ADC_BITS +: ADC_BITS]) :
                          acc_q[k*SW +: SW];
    // the last word lands in the accumulator during QUIET, ahead of FRAME_END
    fsum_d = state_d == FRAME_END ? acc_q : fsum_q;
  end
  always_ff @(posedge fpga_clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      fsum_q <= '0;
    end else begin
      acc_q <= acc_d;
      fsum_q <= fsum_d;
    end
  end
  assign frame_sum = fsum_q;
`endif
endmodule

// File: tb/tb_sensor_frame_reader.sv
// tb_sensor_frame_reader: directed self-checking bench for sensor_frame_reader at default parameters.
module tb_sensor_frame_reader;
  logic fpga_clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic [1:0] serial_data = 2'b00;
  logic SI, sensor_clk, adc_sclk, chip_select, data_valid, frame_done, busy;
  logic [23:0] data_out;
  logic [6:0] pixel_idx;
`ifdef FRAME_SUM_EN
  logic [37:0] frame_sum;
`endif
  int errors = 0;
  int checks = 0;
  logic [11:0] adc_val [2];
  bit ramp = 1'b0;
  int bitn = 0;
  int conv_n = 0;
  logic m_si = 1'b0, m_cs = 1'b1, m_sclk = 1'b1;
  localparam logic [37:0] RST_OUT = {7'b0011000, 31'h0};
  wire [37:0] outs = {SI, sensor_clk, adc_sclk, chip_select, data_valid, frame_done, busy, data_out, pixel_idx};

  always #5 fpga_clk = ~fpga_clk;

  sensor_frame_reader dut (
    .fpga_clk(fpga_clk), .reset(reset), .start(start), .continuous(continuous),
    .serial_data(serial_data), .SI(SI), .sensor_clk(sensor_clk), .adc_sclk(adc_sclk),
    .chip_select(chip_select), .data_out(data_out), .data_valid(data_valid),
    .pixel_idx(pixel_idx), .frame_done(frame_done), .busy(busy)
`ifdef FRAME_SUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  // ADC model: 16 bits per conversion shifted out on SCLK falling edges, 4 leading zeros then 12 bits MSB first
  always @(posedge fpga_clk) begin
    #1;
    if (SI && !m_si) conv_n = 0;
    if (chip_select && !m_cs) begin
      bitn = 0;
      conv_n++;
    end
    if (!adc_sclk && m_sclk && !chip_select) begin
      for (int k = 0; k < 2; k++) begin
        logic [11:0] v;
        v = ramp ? 12'(conv_n) : adc_val[k];
        serial_data[k] = (bitn >= 4) ? ((v >> (15 - bitn)) & 12'h1) != 0 : 1'b0;
      end
      bitn++;
    end
    m_si = SI;
    m_cs = chip_select;
    m_sclk = adc_sclk;
  end

  task automatic pulse_start();
    @(negedge fpga_clk);
    start = 1'b1;
    @(negedge fpga_clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge fpga_clk);
    checks++;
    if (outs !== RST_OUT) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h required=%h", outs, RST_OUT);
    end
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge fpga_clk);
      checks++;
      if (outs !== RST_OUT) begin
        errors++;
        $display("FAIL idle_cycle%0d: outputs=%h required=%h", i, outs, RST_OUT);
      end
    end
  endtask

  task automatic test_single_frame();
    int n = 0;
    int cyc = 0;
    bit done = 1'b0;
    adc_val[0] = 12'hA5C;
    adc_val[1] = 12'h3F1;
    ramp = 1'b0;
    pulse_start();
    while (!done && cyc < 20000) begin
      @(negedge fpga_clk);
      cyc++;
      start = data_valid && pixel_idx == 7'd60;
      if (data_valid) begin
        checks++;
        if (pixel_idx !== 7'(n) || data_out !== 24'h3F1A5C) begin
          errors++;
          $display("FAIL pixel%0d: idx=%0d data=%h required idx=%0d data=3f1a5c", n, pixel_idx, data_out, n);
        end
        n++;
      end
      if (frame_done) done = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!done || n != 128) begin
      errors++;
      $display("FAIL frame_count: done=%0d pixels=%0d required done=1 pixels=128", done, n);
    end
    @(negedge fpga_clk);
    checks++;
    if (busy !== 1'b0 || SI !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL after_frame: busy=%b SI=%b frame_done=%b required 0 0 0", busy, SI, frame_done);
    end
  endtask

  task automatic test_sclk_timing();
    int win = 0;
    int len = 0;
    int rises = 0;
    int cyc = 0;
    logic ps = 1'b1, pcs = 1'b1;
    pulse_start();
    while (win < 3 && cyc < 2000) begin
      @(negedge fpga_clk);
      cyc++;
      if (!chip_select && pcs) begin
        checks++;
        if (ps !== 1'b1) begin
          errors++;
          $display("FAIL sclk_before_window%0d: adc_sclk=%b required 1", win, ps);
        end
        len = 0;
        rises = 0;
      end
      if (!chip_select) begin
        len++;
        if (adc_sclk && !ps && !pcs) rises++;
      end
      if (chip_select && !pcs) begin
        checks++;
        if (len != 64 || rises != 16 || ps !== 1'b1 || adc_sclk !== 1'b1) begin
          errors++;
          $display("FAIL window%0d: len=%0d rises=%0d sclk_end=%b sclk_after=%b required 64 16 1 1",
                   win, len, rises, ps, adc_sclk);
        end
        win++;
      end
      ps = adc_sclk;
      pcs = chip_select;
    end
    checks++;
    if (win != 3) begin
      errors++;
      $display("FAIL sclk_windows: seen=%0d required 3", win);
    end
    reset = 1'b0;
    @(negedge fpga_clk);
    reset = 1'b1;
  endtask

  task automatic test_continuous();
    int fd = 0;
    int cyc = 0;
    int extra = 0;
    continuous = 1'b1;
    pulse_start();
    while (busy && cyc < 40000) begin
      @(negedge fpga_clk);
      cyc++;
      if (frame_done) begin
        fd++;
        @(negedge fpga_clk);
        cyc++;
        checks++;
        if (SI !== (fd < 3)) begin
          errors++;
          $display("FAIL si_after_done%0d: SI=%b required %b", fd, SI, fd < 3);
        end
        if (fd == 2) continuous = 1'b0;
      end
    end
    checks++;
    if (fd != 3) begin
      errors++;
      $display("FAIL continuous_frames: frame_done=%0d required 3", fd);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge fpga_clk);
      if (frame_done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL continuous_stop: active_cycles=%0d required 0", extra);
    end
  endtask

  task automatic test_abort();
    int cyc = 0;
    int stray = 0;
    pulse_start();
    while (!(data_valid && pixel_idx == 7'd49) && cyc < 6000) begin
      @(negedge fpga_clk);
      cyc++;
    end
    while (chip_select && cyc < 6100) begin
      @(negedge fpga_clk);
      cyc++;
    end
    checks++;
    if (cyc >= 6000) begin
      errors++;
      $display("FAIL abort_reach_pixel50: cycles=%0d required <6000", cyc);
    end
    repeat (10) @(negedge fpga_clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (chip_select !== 1'b1 || adc_sclk !== 1'b1 || data_valid !== 1'b0 || busy !== 1'b0 || SI !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate: cs=%b sclk=%b valid=%b busy=%b SI=%b required 1 1 0 0 0",
               chip_select, adc_sclk, data_valid, busy, SI);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge fpga_clk);
      if (data_valid) stray++;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge fpga_clk);
      if (data_valid) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_no_strobe: strobes=%0d required 0", stray);
    end
    pulse_start();
    cyc = 0;
    while (!data_valid && cyc < 200) begin
      @(negedge fpga_clk);
      cyc++;
    end
    checks++;
    if (data_valid !== 1'b1 || pixel_idx !== 7'd0 || data_out !== 24'h3F1A5C) begin
      errors++;
      $display("FAIL restart_first_pixel: valid=%b idx=%0d data=%h required 1 0 3f1a5c",
               data_valid, pixel_idx, data_out);
    end
    reset = 1'b0;
    @(negedge fpga_clk);
    reset = 1'b1;
  endtask

`ifdef FRAME_SUM_EN
  task automatic test_frame_sum();
    int cyc = 0;
    ramp = 1'b1;
    pulse_start();
    while (!frame_done && cyc < 20000) begin
      @(negedge fpga_clk);
      cyc++;
    end
    checks++;
    if (frame_done !== 1'b1 || frame_sum !== {19'd8128, 19'd8128}) begin
      errors++;
      $display("FAIL frame_sum: done=%b sum=%h required 1 %h", frame_done, frame_sum, {19'd8128, 19'd8128});
    end
    ramp = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_sclk_timing();
    test_continuous();
    test_abort();
`ifdef FRAME_SUM_EN
    test_frame_sum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
